// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 core: captures decoder controls and operands,
// inserts a bubble on load-use hazards, honours flush, and counts stall bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic [3:0]       id_alu_control,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic [3:0]       ex_alu_control,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Control bundle: {mem_read, mem_write, branch, reg_write, alu_op, alu_control}
  logic             valid_q, valid_d;
  logic [9:0]       ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, uses_rs2;

  assign load     = ex_ready | ~valid_q;
  assign uses_rs2 = id_mem_write | id_branch | (id_alu_op == 2'b10);

  assign hazard_stall = valid_q & ctrl_q[9] & (rd_q != 5'd0) & id_valid &
                        ((rd_q == id_rs1) | (uses_rs2 & (rd_q == id_rs2)));
  assign id_ready     = flush | (load & ~hazard_stall);

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      if (id_valid & ~hazard_stall) begin
        valid_d    = 1'b1;
        ctrl_d     = {id_mem_read, id_mem_write, id_branch, id_reg_write, id_alu_op, id_alu_control};
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
      end else begin
        // Bubble: kill controls but leave data/indices untouched
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      if (hazard_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_mem_read    = ctrl_q[9];
  assign ex_mem_write   = ctrl_q[8];
  assign ex_branch      = ctrl_q[7];
  assign ex_reg_write   = ctrl_q[6];
  assign ex_alu_op      = ctrl_q[5:4];
  assign ex_alu_control = ctrl_q[3:0];
  assign ex_pc          = pc_q;
  assign ex_rs1_data    = rs1_data_q;
  assign ex_rs2_data    = rs2_data_q;
  assign ex_imm         = imm_q;
  assign ex_rs1         = rs1_q;
  assign ex_rs2         = rs2_q;
  assign ex_rd          = rd_q;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a reference model;
// a second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, ex_ready, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_mem_read, id_mem_write, id_branch, id_reg_write;
  logic [1:0]  id_alu_op;
  logic [3:0]  id_alu_control;

  logic        id_ready, ex_valid, hazard_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_branch, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [3:0]  ex_alu_control;
  logic [15:0] stall_cnt;

  logic        b_id_ready, b_ex_valid, b_hazard_stall;
  logic [31:0] b_ex_pc, b_ex_rs1_data, b_ex_rs2_data, b_ex_imm;
  logic [4:0]  b_ex_rs1, b_ex_rs2, b_ex_rd;
  logic        b_ex_mem_read, b_ex_mem_write, b_ex_branch, b_ex_reg_write;
  logic [1:0]  b_ex_alu_op;
  logic [3:0]  b_ex_alu_control;
  logic [1:0]  b_stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_alu_control(id_alu_control),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_alu_control(ex_alu_control),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(b_id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_alu_control(id_alu_control),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(b_ex_valid),
    .ex_pc(b_ex_pc), .ex_rs1_data(b_ex_rs1_data), .ex_rs2_data(b_ex_rs2_data), .ex_imm(b_ex_imm),
    .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2), .ex_rd(b_ex_rd),
    .ex_mem_read(b_ex_mem_read), .ex_mem_write(b_ex_mem_write), .ex_branch(b_ex_branch),
    .ex_reg_write(b_ex_reg_write), .ex_alu_op(b_ex_alu_op), .ex_alu_control(b_ex_alu_control),
    .hazard_stall(b_hazard_stall), .stall_cnt(b_stall_cnt)
  );

  // Reference model of what the EX register should hold
  typedef struct packed {
    logic        v;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1, r2, rd;
    logic        mr, mw, br, rw;
    logic [1:0]  aop;
    logic [3:0]  actl;
  } ex_t;

  ex_t m, m_next;
  int  m_cnt16, m_cnt2, n_cnt16, n_cnt2;
  bit  inited = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hz();
    bit reads_rs2 = id_mem_write || id_branch || (id_alu_op == 2'b10);
    return m.v && m.mr && (m.rd != 0) && id_valid &&
           ((m.rd == id_rs1) || (reads_rs2 && (m.rd == id_rs2)));
  endfunction

  function automatic bit m_rdy();
    return flush || ((ex_ready || !m.v) && !m_hz());
  endfunction

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic mw, input logic br,
                           input logic rw, input logic [1:0] aop, input logic [3:0] actl);
    id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_mem_read = mr; id_mem_write = mw; id_branch = br; id_reg_write = rw;
    id_alu_op = aop; id_alu_control = actl;
  endtask

  task automatic cyc_a();
    @(negedge clk);
    if (inited) begin
      chk("hazard", 64'(hazard_stall), 64'(m_hz()));
      chk("id_ready", 64'(id_ready), 64'(m_rdy()));
      chk("b_comb", 64'({b_hazard_stall, b_id_ready}), 64'({m_hz(), m_rdy()}));
    end
  endtask

  task automatic cyc_b();
    bit ld = ex_ready || !m.v;
    bit hz = m_hz();
    m_next = m; n_cnt16 = m_cnt16; n_cnt2 = m_cnt2;
    if (reset) begin
      m_next = '0; n_cnt16 = 0; n_cnt2 = 0;
    end else if (flush) begin
      m_next.v = 0; m_next.mr = 0; m_next.mw = 0; m_next.br = 0; m_next.rw = 0;
      m_next.aop = 0; m_next.actl = 0;
    end else if (ld) begin
      if (id_valid && !hz)
        m_next = '{1'b1, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
                   id_mem_read, id_mem_write, id_branch, id_reg_write, id_alu_op, id_alu_control};
      else begin
        m_next.v = 0; m_next.mr = 0; m_next.mw = 0; m_next.br = 0; m_next.rw = 0;
        m_next.aop = 0; m_next.actl = 0;
      end
      if (hz) begin
        n_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
        n_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
    @(posedge clk);
    #1;
    m = m_next; m_cnt16 = n_cnt16; m_cnt2 = n_cnt2;
    if (reset) inited = 1;
    if (inited) begin
      chk("ex_valid", 64'(ex_valid), 64'(m.v));
      chk("ex_pc", 64'(ex_pc), 64'(m.pc));
      chk("ex_rs1_data", 64'(ex_rs1_data), 64'(m.r1d));
      chk("ex_rs2_data", 64'(ex_rs2_data), 64'(m.r2d));
      chk("ex_imm", 64'(ex_imm), 64'(m.imm));
      chk("ex_idx", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({m.r1, m.r2, m.rd}));
      chk("ex_ctrl", 64'({ex_mem_read, ex_mem_write, ex_branch, ex_reg_write}),
          64'({m.mr, m.mw, m.br, m.rw}));
      chk("ex_alu", 64'({ex_alu_op, ex_alu_control}), 64'({m.aop, m.actl}));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt16));
      chk("b_stall_cnt", 64'(b_stall_cnt), 64'(m_cnt2));
      checks++;
      assert ({b_ex_valid, b_ex_pc, b_ex_rs1_data, b_ex_rs2_data, b_ex_imm, b_ex_rs1, b_ex_rs2,
               b_ex_rd, b_ex_mem_read, b_ex_mem_write, b_ex_branch, b_ex_reg_write,
               b_ex_alu_op, b_ex_alu_control} === m) else begin
        errors++;
        $error("FAIL b_regs observed pc %0h valid %0b expected pc %0h valid %0b",
               b_ex_pc, b_ex_valid, m.pc, m.v);
      end
    end
  endtask

  task automatic step();
    cyc_a();
    cyc_b();
  endtask

  initial begin
    m = '0; m_cnt16 = 0; m_cnt2 = 0;
    reset = 1; flush = 0; ex_ready = 1; id_valid = 1;
    set_instr(32'h10, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    step(); step();
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    reset = 0; id_valid = 0;
    cyc_a();
    chk("rst_id_ready", 64'(id_ready), 64'd1);
    cyc_b();

    // R-type pass-through
    id_valid = 1;
    set_instr(32'h40, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010);
    step();
    chk("pt_valid", 64'(ex_valid), 64'd1);
    chk("pt_reg_write", 64'(ex_reg_write), 64'd1);
    chk("pt_pc", 64'(ex_pc), 64'h40);
    chk("pt_rd", 64'(ex_rd), 64'd5);

    // Load-use on rs2
    set_instr(32'h44, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    step();
    set_instr(32'h48, 5'd2, 5'd7, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010);
    cyc_a();
    chk("lu_hazard", 64'(hazard_stall), 64'd1);
    chk("lu_id_ready", 64'(id_ready), 64'd0);
    cyc_b();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    cyc_a();
    chk("lu_clear", 64'(hazard_stall), 64'd0);
    cyc_b();
    chk("lu_capture", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h48}));

    // No false hazards: rd = x0, and rs2 of a load is unused
    set_instr(32'h50, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    step();
    set_instr(32'h54, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010);
    cyc_a();
    chk("nf_x0_hazard", 64'(hazard_stall), 64'd0);
    cyc_b();
    chk("nf_x0_capture", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h54}));
    set_instr(32'h58, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    step();
    set_instr(32'h5C, 5'd1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    cyc_a();
    chk("nf_rs2_hazard", 64'(hazard_stall), 64'd0);
    cyc_b();
    chk("nf_rs2_capture", 64'({ex_valid, ex_pc}), 64'({1'b1, 32'h5C}));

    // Backpressure holding a store behind
    ex_ready = 0;
    set_instr(32'h100, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc_a();
      chk("bp_id_ready", 64'(id_ready), 64'd0);
      cyc_b();
      chk("bp_hold", 64'({ex_valid, ex_pc, ex_rd}), 64'({1'b1, 32'h5C, 5'd4}));
    end
    ex_ready = 1;
    step();
    chk("bp_capture", 64'({ex_pc, ex_mem_write}), 64'({32'h100, 1'b1}));

    // Flush while stalled downstream
    ex_ready = 0; flush = 1;
    cyc_a();
    chk("fl_id_ready", 64'(id_ready), 64'd1);
    cyc_b();
    chk("fl_kill", 64'({ex_valid, ex_mem_write}), 64'd0);
    flush = 0; ex_ready = 1;

    // Reset asserted in the middle of a stall
    set_instr(32'h200, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
    step();
    set_instr(32'h204, 5'd9, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0000);
    cyc_a();
    chk("rs_hazard", 64'(hazard_stall), 64'd1);
    reset = 1;
    cyc_b();
    chk("rs_state", 64'({ex_valid, ex_rd, stall_cnt}), 64'd0);
    reset = 0;

    // Five load-use bubbles: 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      set_instr(32'h300 + 32'(i * 8), 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010);
      step();
      set_instr(32'h304 + 32'(i * 8), 5'd9, 5'd2, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'b0010);
      step();
      step();
    end
    chk("sat_cnt2", 64'(b_stall_cnt), 64'd3);
    chk("sat_cnt16", 64'(stall_cnt), 64'd5);

    // Random traffic with narrow register indices to provoke hazards
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      id_valid = ($urandom_range(0, 4) != 0);
      set_instr($urandom, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                5'($urandom_range(0, 5)), ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register for the RV32 core. It sits directly downstream of the opcode decoder and captures its control outputs (mem_read, mem_write, branch, reg_write, ALUOp, ALUControl) together with the operand, immediate and register-index fields for the EX stage. It provides a valid/ready handshake in both directions and detects load-use hazards, inserting a one-cycle bubble when one occurs. It accepts a flush from branch resolution and keeps a saturating count of stall bubbles for performance reporting.

Parameters:
XLEN, 32, data/PC width
CNT_W, 16, width of the stall-bubble counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage accepts the decode instruction this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  rs1 operand value
id_rs2_data  in  XLEN  rs2 operand value
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  5  rs1 index
id_rs2  in  5  rs2 index
id_rd  in  5  rd index
id_mem_read  in  1  decoder control signal
id_mem_write  in  1  decoder control signal
id_branch  in  1  decoder control signal
id_reg_write  in  1  decoder control signal
id_alu_op  in  2  decoder ALUOp
id_alu_control  in  4  decoder ALUControl
flush  in  1  squash decode and EX-register contents
ex_ready  in  1  EX stage accepts the current output
ex_valid  out  1  output register holds a live instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
ex_mem_read, ex_mem_write, ex_branch, ex_reg_write  out  1 each  registered controls
ex_alu_op  out  2  registered ALUOp
ex_alu_control  out  4  registered ALUControl
hazard_stall  out  1  load-use hazard detected this cycle
stall_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (synchronous): every ex_* output is 0, stall_cnt is 0, and ex_valid is 0. Reset takes priority over all other inputs, including a reset asserted mid-stall.
- load = ex_ready | ~ex_valid. When load is 0, all ex_* outputs hold their values.
- uses_rs2 = id_mem_write | id_branch | (id_alu_op == 2'b10). rs1 is always treated as used.
- hazard_stall (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2))).
- id_ready = flush | (load & ~hazard_stall).
- Priority at each rising edge: reset > flush > load.
  - flush: ex_valid becomes 0 and the four 1-bit controls, ex_alu_op and ex_alu_control become 0, regardless of ex_ready. The decode instruction is consumed and discarded.
  - load & id_valid & ~hazard_stall: all id_* fields are captured and ex_valid becomes 1. Latency is one cycle.
  - load & (hazard_stall | ~id_valid): a bubble is inserted. ex_valid and all controls become 0. Data and index fields hold.
- Invariant: whenever ex_valid = 0, ex_mem_read, ex_mem_write, ex_branch and ex_reg_write are all 0.
- stall_cnt increments by 1 on each edge where load & hazard_stall & ~flush, and saturates at 2^CNT_W − 1.
- A hazard is cleared by the bubble itself, so a load-use pair costs exactly one stall cycle when ex_ready = 1.
- rd = x0 never causes a hazard.

Test Plan:
- Reset: hold reset for 2 cycles with id_valid = 1 -> ex_valid = 0, all controls 0, stall_cnt = 0, id_ready = 1 after release.
- Pass-through: R-type input (alu_op = 10, alu_control = 0010, rd = 5, pc = 0x40) with ex_ready = 1 -> the next cycle shows ex_valid = 1, ex_reg_write = 1, ex_pc = 0x40, ex_rd = 5.
- Load-use: LW with rd = 7, followed by ADD with rs2 = 7 -> hazard_stall = 1 and id_ready = 0 for one cycle. A bubble appears (ex_valid = 0) and stall_cnt = 1. The ADD is captured on the following cycle.
- No false hazard: LW with rd = 0 then ADD with rs1 = 0, and separately LW with rd = 3 then LW with rs2 = 3 (rs2 unused) -> hazard_stall stays 0 and no bubble is inserted.
- Backpressure: ex_ready = 0 for 3 cycles while ex_valid = 1 -> ex_* outputs are unchanged and id_ready = 0. The next input is captured on the cycle after ex_ready returns to 1.
- Flush: flush = 1 while ex_valid = 1, ex_ready = 0, ex_mem_write = 1 -> the next cycle shows ex_valid = 0 and ex_mem_write = 0, and id_ready = 1 during the flush cycle.
- Saturation: with CNT_W = 2, force 5 load-use bubbles -> stall_cnt = 3.
